// File: rtl/proc_write_unit_pkg.sv
// Shared definitions for the ARM-side ping-pong feature buffer writer.
package proc_write_unit_pkg;

  localparam int unsigned FEATURE_WIDTH_DEF = 16;
  localparam int unsigned ADDR_WIDTH_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BANK = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } wr_state_e;

  typedef logic bank_t;

endpackage

// File: rtl/proc_pingpong_status.sv
// Fill pointer and per-bank full flags shared between the ARM writer and compute side.
module proc_pingpong_status
  import proc_write_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic set_strobe,
  input  logic set_bank,
  input  logic release_0,
  input  logic release_1,
  output logic fill_ptr,
  output logic full_0,
  output logic full_1
);

  bank_t fill_ptr_q, fill_ptr_d;
  logic  full_0_q, full_0_d;
  logic  full_1_q, full_1_d;

  // Release is applied first so a same-cycle set on that bank overrides it.
  always_comb begin
    fill_ptr_d = fill_ptr_q;
    full_0_d   = full_0_q & ~release_0;
    full_1_d   = full_1_q & ~release_1;
    if (set_strobe) begin
      if (set_bank == 1'b0) full_0_d = 1'b1;
      else                  full_1_d = 1'b1;
      fill_ptr_d = ~fill_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_ptr_q <= 1'b0;
      full_0_q   <= 1'b0;
      full_1_q   <= 1'b0;
    end else begin
      fill_ptr_q <= fill_ptr_d;
      full_0_q   <= full_0_d;
      full_1_q   <= full_1_d;
    end
  end

  assign fill_ptr = fill_ptr_q;
  assign full_0   = full_0_q;
  assign full_1   = full_1_q;

endmodule

// File: rtl/proc_write_unit.sv
// ARM burst writer: streams 2-feature words into the ping-pong bank selected by the fill pointer.
module proc_write_unit
  import proc_write_unit_pkg::*;
#(
  parameter int unsigned FEATURE_WIDTH = FEATURE_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arm_write_start,
  input  logic [ADDR_WIDTH-1:0]        arm_write_base,
  input  logic [ADDR_WIDTH-1:0]        arm_write_len,
  input  logic                         arm_write_valid,
  input  logic [FEATURE_WIDTH*2-1:0]   arm_write_data,
  output logic                         arm_write_ready,
  output logic                         arm_write_done,
  output logic                         arm_write_bank,
  output logic                         busy,
  input  logic                         bank_release_0,
  input  logic                         bank_release_1,
  output logic                         bank_full_0,
  output logic                         bank_full_1,
  output logic                         write_enable_0,
  output logic [ADDR_WIDTH-1:0]        write_addr_0,
  output logic [FEATURE_WIDTH*2-1:0]   write_data_0,
  output logic                         write_enable_1,
  output logic [ADDR_WIDTH-1:0]        write_addr_1,
  output logic [FEATURE_WIDTH*2-1:0]   write_data_1
);

  localparam int unsigned DATA_WIDTH = FEATURE_WIDTH * 2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  wr_state_e               state_q, state_d;
  bank_t                   tgt_q, tgt_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0]   count_q, count_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic  fill_ptr;
  logic  full_tgt;
  logic  full_fill;
  logic  release_tgt;
  logic  set_strobe;

  proc_pingpong_status u_status (
    .clk        (clk),
    .rst        (rst),
    .set_strobe (set_strobe),
    .set_bank   (tgt_q),
    .release_0  (bank_release_0),
    .release_1  (bank_release_1),
    .fill_ptr   (fill_ptr),
    .full_0     (bank_full_0),
    .full_1     (bank_full_1)
  );

  assign full_tgt    = tgt_q    ? bank_full_1    : bank_full_0;
  assign full_fill   = fill_ptr ? bank_full_1    : bank_full_0;
  assign release_tgt = tgt_q    ? bank_release_1 : bank_release_0;
  assign set_strobe  = (state_q == DONE) && (len_q != '0);

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    base_d  = base_q;
    len_d   = len_q;
    count_d = count_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (arm_write_start) begin
          base_d  = arm_write_base;
          len_d   = arm_write_len;
          tgt_d   = fill_ptr;
          count_d = '0;
          if (arm_write_len == '0) state_d = DONE;
          else if (full_fill)      state_d = WAIT_BANK;
          else                     state_d = WRITE;
        end
      end
      WAIT_BANK: begin
        // A release landing this cycle is enough; no need to wait for the flag to drop.
        if (!full_tgt || release_tgt) state_d = WRITE;
      end
      WRITE: begin
        if (arm_write_valid) begin
          we_d    = 1'b1;
          waddr_d = base_q + count_q;
          wdata_d = arm_write_data;
          count_d = count_q + ADDR_ONE;
          if (count_q + ADDR_ONE == len_q) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      base_q  <= base_d;
      len_q   <= len_d;
      count_q <= count_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign arm_write_ready = (state_q == WRITE);
  assign arm_write_done  = (state_q == DONE);
  assign arm_write_bank  = tgt_q;
  assign busy            = (state_q != IDLE);

  assign write_enable_0 = we_q & ~tgt_q;
  assign write_addr_0   = tgt_q ? '0 : waddr_q;
  assign write_data_0   = tgt_q ? '0 : wdata_q;
  assign write_enable_1 = we_q & tgt_q;
  assign write_addr_1   = tgt_q ? waddr_q : '0;
  assign write_data_1   = tgt_q ? wdata_q : '0;

endmodule

// File: tb/tb_proc_write_unit.sv
// Randomized bench for proc_write_unit against a burst-level model of banks, flags and addresses.
module tb_proc_write_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm_write_start = 1'b0;
  logic [15:0] arm_write_base = '0;
  logic [15:0] arm_write_len = '0;
  logic        arm_write_valid = 1'b0;
  logic [31:0] arm_write_data = '0;
  logic        arm_write_ready, arm_write_done, arm_write_bank, busy;
  logic        bank_release_0 = 1'b0, bank_release_1 = 1'b0;
  logic        bank_full_0, bank_full_1;
  logic        write_enable_0, write_enable_1;
  logic [15:0] write_addr_0, write_addr_1;
  logic [31:0] write_data_0, write_data_1;

  proc_write_unit #(.FEATURE_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .arm_write_start(arm_write_start), .arm_write_base(arm_write_base),
    .arm_write_len(arm_write_len), .arm_write_valid(arm_write_valid),
    .arm_write_data(arm_write_data), .arm_write_ready(arm_write_ready),
    .arm_write_done(arm_write_done), .arm_write_bank(arm_write_bank), .busy(busy),
    .bank_release_0(bank_release_0), .bank_release_1(bank_release_1),
    .bank_full_0(bank_full_0), .bank_full_1(bank_full_1),
    .write_enable_0(write_enable_0), .write_addr_0(write_addr_0), .write_data_0(write_data_0),
    .write_enable_1(write_enable_1), .write_addr_1(write_addr_1), .write_data_1(write_data_1)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit m_fill = 1'b0;
  bit m_full [2] = '{1'b0, 1'b0};

  logic [48:0] obs_q[$];
  int bad_both = 0;
  int bad_nt = 0;

  always @(negedge clk) begin
    if (write_enable_0 && write_enable_1) bad_both++;
    if (!arm_write_bank && (write_enable_1 || write_addr_1 != '0 || write_data_1 != '0)) bad_nt++;
    if (arm_write_bank && (write_enable_0 || write_addr_0 != '0 || write_data_0 != '0)) bad_nt++;
    if (write_enable_0) obs_q.push_back({1'b0, write_addr_0, write_data_0});
    if (write_enable_1) obs_q.push_back({1'b1, write_addr_1, write_data_1});
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({arm_write_ready, arm_write_done, arm_write_bank, busy, bank_full_0, bank_full_1,
         write_enable_0, write_addr_0, write_data_0, write_enable_1, write_addr_1, write_data_1} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ready=%b done=%b bank=%b busy=%b full=%b%b we=%b%b, want all 0",
               arm_write_ready, arm_write_done, arm_write_bank, busy, bank_full_1, bank_full_0,
               write_enable_1, write_enable_0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_release(input bit b);
    if (b) bank_release_1 = 1'b1; else bank_release_0 = 1'b1;
    @(posedge clk); #1;
    bank_release_0 = 1'b0;
    bank_release_1 = 1'b0;
    m_full[b] = 1'b0;
    vectors++;
    if ({bank_full_1, bank_full_0} !== {m_full[1], m_full[0]}) begin
      miscompares++;
      $display("FAIL release_bank%0d: got full=%b%b, want %b%b", b, bank_full_1, bank_full_0, m_full[1], m_full[0]);
    end
  endtask

  // One burst from start pulse to the IDLE cycle after DONE; entered and left at posedge+1.
  task automatic do_burst(input string nm, input logic [15:0] base, input logic [15:0] len,
                          input int vprob, input bit noise, input int rel_wait,
                          input bit rel_at_done, input int exp_cycles);
    logic [48:0] exp_q[$];
    bit tgt, will_wait, rel_next, seen_done, first;
    int acc, cyc, obs_start, bad_wait;
    tgt = m_fill;
    will_wait = (len != 0) && m_full[tgt];
    acc = 0; cyc = 0; rel_next = 0; seen_done = 0; first = 1; bad_wait = 0;
    obs_start = obs_q.size();
    arm_write_base = base;
    arm_write_len = len;
    arm_write_start = 1'b1;
    @(posedge clk); #1;
    arm_write_start = 1'b0;
    arm_write_base = 16'($urandom);
    arm_write_len = 16'($urandom);
    if (will_wait) begin
      repeat (rel_wait) begin
        @(negedge clk);
        if (arm_write_ready !== 1'b0 || busy !== 1'b1) bad_wait++;
        @(posedge clk); #1;
      end
      if (tgt) bank_release_1 = 1'b1; else bank_release_0 = 1'b1;
      @(negedge clk);
      if (arm_write_ready !== 1'b0) bad_wait++;
      @(posedge clk); #1;
      bank_release_0 = 1'b0;
      bank_release_1 = 1'b0;
      m_full[tgt] = 1'b0;
      vectors++;
      if (bad_wait != 0) begin
        miscompares++;
        $display("FAIL %s wait_ready_low: got %0d bad cycles, want 0", nm, bad_wait);
      end
    end
    while (!seen_done && cyc < 300) begin
      arm_write_valid = ($urandom_range(99) < vprob);
      arm_write_data = $urandom;
      if (noise) begin
        arm_write_start = 1'($urandom_range(1));
        arm_write_base = 16'($urandom);
        arm_write_len = 16'($urandom);
      end
      if (rel_next) begin
        if (tgt) bank_release_1 = 1'b1; else bank_release_0 = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (first && will_wait) begin
        vectors++;
        if (arm_write_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL %s resume_ready: got %b, want 1", nm, arm_write_ready);
        end
      end
      first = 0;
      if (arm_write_done === 1'b1) begin
        seen_done = 1;
        vectors++;
        if (arm_write_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL %s ready_in_done: got %b, want 0", nm, arm_write_ready);
        end
      end else if (arm_write_ready === 1'b1 && arm_write_valid) begin
        exp_q.push_back({tgt, base + 16'(acc), arm_write_data});
        acc++;
        if (acc == int'(len) && rel_at_done) rel_next = 1;
      end
      @(posedge clk); #1;
    end
    arm_write_valid = 1'b0;
    arm_write_start = 1'b0;
    bank_release_0 = 1'b0;
    bank_release_1 = 1'b0;
    if (len != 0) begin
      m_full[tgt] = 1'b1;
      m_fill = ~m_fill;
    end
    vectors++;
    if (!seen_done) begin
      miscompares++;
      $display("FAIL %s done_pulse: got none in %0d cycles, want one", nm, cyc);
    end
    if (exp_cycles >= 0) begin
      vectors++;
      if (cyc != exp_cycles) begin
        miscompares++;
        $display("FAIL %s latency: got done after %0d cycles, want %0d", nm, cyc, exp_cycles);
      end
    end
    vectors++;
    if (acc != int'(len)) begin
      miscompares++;
      $display("FAIL %s accepted: got %0d words, want %0d", nm, acc, len);
    end
    vectors++;
    if (obs_q.size() - obs_start != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s strobes: got %0d, want %0d", nm, obs_q.size() - obs_start, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (obs_q[obs_start + i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL %s write%0d: got bank/addr/data %h, want %h", nm, i, obs_q[obs_start + i], exp_q[i]);
        end
      end
    end
    vectors++;
    if ({bank_full_1, bank_full_0, arm_write_bank, busy} !== {m_full[1], m_full[0], tgt, 1'b0}) begin
      miscompares++;
      $display("FAIL %s status: got full=%b%b bank=%b busy=%b, want full=%b%b bank=%b busy=0",
               nm, bank_full_1, bank_full_0, arm_write_bank, busy, m_full[1], m_full[0], tgt);
    end
    vectors++;
    if (bad_both != 0 || bad_nt != 0) begin
      miscompares++;
      $display("FAIL %s bank_isolation: got %0d dual strobes, %0d non-target nonzero, want 0", nm, bad_both, bad_nt);
    end
  endtask

  task automatic test_basic_burst;
    do_burst("basic", 16'h0010, 16'd4, 100, 1'b0, 0, 1'b0, 5);
  endtask

  task automatic test_second_bank;
    do_burst("second_bank", 16'($urandom), 16'd2, 100, 1'b0, 0, 1'b0, 3);
  endtask

  task automatic test_wait_bank;
    do_burst("wait_bank", 16'($urandom), 16'd3, 100, 1'b0, 4, 1'b0, -1);
  endtask

  task automatic test_addr_wrap;
    test_release(1'b1);
    do_burst("addr_wrap", 16'hFFFE, 16'd4, 100, 1'b0, 0, 1'b0, 5);
  endtask

  task automatic test_valid_gaps;
    test_release(1'b0);
    do_burst("valid_gaps", 16'($urandom), 16'd3, 40, 1'b0, 0, 1'b0, -1);
  endtask

  task automatic test_len_zero;
    do_burst("len_zero", 16'($urandom), 16'd0, 100, 1'b0, 0, 1'b0, 1);
  endtask

  task automatic test_start_ignored;
    test_release(1'b1);
    do_burst("start_ignored", 16'($urandom), 16'd5, 100, 1'b1, 0, 1'b0, 6);
  endtask

  task automatic test_set_over_release;
    test_release(1'b0);
    do_burst("set_over_release", 16'($urandom), 16'd3, 100, 1'b0, 0, 1'b1, 4);
    test_release(1'b1);
    test_release(1'b1);
  endtask

  task automatic test_reset_mid_burst;
    int acc, guard, bad_done;
    test_release(1'b0);
    test_release(1'b1);
    acc = 0; guard = 0; bad_done = 0;
    arm_write_base = 16'($urandom);
    arm_write_len = 16'd5;
    arm_write_start = 1'b1;
    @(posedge clk); #1;
    arm_write_start = 1'b0;
    arm_write_valid = 1'b1;
    while (acc < 2 && guard < 20) begin
      arm_write_data = $urandom;
      @(negedge clk);
      guard++;
      if (arm_write_ready === 1'b1) acc++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    arm_write_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_fill = 1'b0;
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
    @(negedge clk);
    vectors++;
    if ({arm_write_ready, arm_write_done, arm_write_bank, busy, bank_full_0, bank_full_1,
         write_enable_0, write_addr_0, write_data_0, write_enable_1, write_addr_1, write_data_1} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got ready=%b done=%b bank=%b busy=%b full=%b%b we=%b%b, want all 0",
               arm_write_ready, arm_write_done, arm_write_bank, busy, bank_full_1, bank_full_0,
               write_enable_1, write_enable_0);
    end
    repeat (3) begin
      @(negedge clk);
      if (arm_write_done !== 1'b0 || busy !== 1'b0) bad_done++;
    end
    vectors++;
    if (bad_done != 0 || acc != 2) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: got %0d late done/busy cycles, %0d words before reset, want 0 and 2", bad_done, acc);
    end
    @(posedge clk); #1;
    do_burst("after_reset", 16'($urandom), 16'd2, 100, 1'b0, 0, 1'b0, 3);
  endtask

  task automatic test_random;
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(1) == 1) test_release(1'($urandom_range(1)));
      do_burst("random", 16'($urandom), 16'($urandom_range(0, 6)), int'($urandom_range(30, 100)),
               1'($urandom_range(1)), int'($urandom_range(0, 3)), 1'($urandom_range(1)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_second_bank();
    test_wait_bank();
    test_addr_wrap();
    test_valid_gaps();
    test_len_zero();
    test_start_ignored();
    test_set_over_release();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by %0t, want bench to finish", $time);
    $fatal(1, "time limit");
  end

endmodule
